// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into whole-word data_memory accesses,
// using read-modify-write for sub-word stores and flagging misaligned/out-of-range requests.
module load_store_unit #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLh  = 3'd1,
        OpLw  = 3'd2,
        OpSw  = 3'd3,
        OpLbu = 3'd4,
        OpLhu = 3'd5,
        OpSb  = 3'd6,
        OpSh  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StRmwRd,
        StRmwWr,
        StResp,
        StErr
    } state_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;

    op_e         op_in;
    logic        is_load_in;
    logic        is_half_in;
    logic        is_word_in;
    logic        is_sub_store_in;
    logic        misaligned_in;
    logic        out_of_range_in;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classify the incoming request so the accept edge can pick the next state directly.
    always_comb begin
        op_in           = op_e'(op);
        is_load_in      = 1'b0;
        is_half_in      = 1'b0;
        is_word_in      = 1'b0;
        is_sub_store_in = 1'b0;
        unique case (op_in)
            OpLb, OpLbu: is_load_in = 1'b1;
            OpLh, OpLhu: begin
                is_load_in = 1'b1;
                is_half_in = 1'b1;
            end
            OpLw: begin
                is_load_in = 1'b1;
                is_word_in = 1'b1;
            end
            OpSw: is_word_in = 1'b1;
            OpSb: is_sub_store_in = 1'b1;
            OpSh: begin
                is_half_in      = 1'b1;
                is_sub_store_in = 1'b1;
            end
            default: ;
        endcase
        misaligned_in   = (is_half_in && addr[0]) || (is_word_in && (addr[1:0] != 2'b00));
        out_of_range_in = CHECK_RANGE && ({2'b00, addr[31:2]} >= MEM_WORDS);
    end

    // Little-endian lane extraction and extension for loads.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (op_q)
            OpLb:    load_val = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_val = {24'h000000, byte_sel};
            OpLh:    load_val = {{16{half_sel[15]}}, half_sel};
            OpLhu:   load_val = {16'h0000, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Replace the target lane(s) of the captured word with the store data.
    always_comb begin
        merged = buf_q;
        if (op_q == OpSh) begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0000_0000;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req) begin
                    op_d    = op_in;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (misaligned_in || out_of_range_in) begin
                        state_d = StErr;
                    end else if (is_load_in) begin
                        state_d = StLoad;
                    end else if (is_sub_store_in) begin
                        state_d = StRmwRd;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_val;
                state_d = StResp;
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
                state_d   = StResp;
            end
            StRmwRd: begin
                buf_d   = mem_rdata;
                state_d = StRmwWr;
            end
            StRmwWr: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_d   = StResp;
            end
            StResp: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = ~req_ready;
    assign rdata    = rdata_q;
    assign mem_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OpLb;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            buf_q   <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences and a
// randomized run checked against a byte-lane memory model.
module tb_load_store_unit;

    localparam int unsigned MemWords = 256;

    logic        clk;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    load_store_unit #(
        .MEM_WORDS  (MemWords),
        .CHECK_RANGE(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .req_ready(req_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory stand-in: combinational read, write on rising edge, cleared by rst.
    logic [31:0] mem [MemWords];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MemWords; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    int we_count = 0;
    int we_bad   = 0;
    always @(posedge clk) if (rst && mem_we) we_count <= we_count + 1;
    always @(negedge clk) if (rst && mem_we && (req_ready || done || err)) we_bad <= we_bad + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: plain word array plus last load result.
    logic [31:0] ref_mem [MemWords];
    logic [31:0] ref_rdata;

    function automatic int unsigned m_size(input logic [2:0] o);
        case (o)
            3'd0, 3'd4, 3'd6: return 1;
            3'd1, 3'd5, 3'd7: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_is_load(input logic [2:0] o);
        return (o == 3'd0) || (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd5);
    endfunction

    function automatic bit m_err(input logic [2:0] o, input logic [31:0] a);
        int unsigned sz;
        sz = m_size(o);
        return ((a % sz) != 0) || ((a / 4) >= MemWords);
    endfunction

    function automatic int m_lat(input logic [2:0] o);
        return (o == 3'd6 || o == 3'd7) ? 3 : 2;
    endfunction

    task automatic model_step(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                              output bit e, output logic [31:0] rd);
        int unsigned sz, sh, idx;
        logic [31:0] word, lane, mask;
        sz = m_size(o);
        e  = m_err(o, a);
        if (!e) begin
            idx  = a / 4;
            sh   = (a % 4) * 8;
            word = ref_mem[idx];
            mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 1) << sh);
            if (m_is_load(o)) begin
                lane = (word & mask) >> sh;
                if ((o == 3'd0 || o == 3'd1) && lane >= (32'd1 << (8 * sz - 1)))
                    lane = lane - (32'd1 << (8 * sz));
                ref_rdata = lane;
            end else begin
                ref_mem[idx] = (word & ~mask) | ((d << sh) & mask);
            end
        end
        rd = ref_rdata;
    endtask

    // Issue one request from a falling edge; wait (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int wes, output bit found);
        int w0;
        for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
        w0    = we_count;
        found = 1'b0;
        lat   = 0;
        rd    = 32'h0;
        er    = 1'b0;
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        op    = 3'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        for (int i = 1; i <= 8 && !found; i++) begin
            if (i > 1) @(negedge clk);
            if (done) begin
                found = 1'b1;
                lat   = i;
                rd    = rdata;
                er    = err;
            end
        end
        @(negedge clk);
        wes = we_count - w0;
    endtask

    task automatic exercise(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] d, input bit chk_rd, input logic [31:0] exp_rd,
                            input bit exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat, wes;
        bit          found;
        run_op(o, a, d, rd, er, lat, wes, found);
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s done: no done within 8 cycles, expected within %0d", tag, exp_lat);
        end else begin
            check({tag, " err"}, er, exp_err);
            if (exp_err) check({tag, " err-latency<=2"}, lat <= 2, 1'b1);
            else check({tag, " latency"}, lat, exp_lat);
            check({tag, " writes"}, wes, (!exp_err && !m_is_load(o)) ? 1 : 0);
            if (chk_rd) check({tag, " rdata"}, rd, exp_rd);
        end
    endtask

    task automatic check_memory(input string tag);
        int bad = 0;
        for (int i = 0; i < MemWords; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, " words differing"}, bad, 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    initial begin : main
        vec_t        vecs[$];
        bit          e;
        logic [31:0] rd;
        int          w0, r;
        logic [2:0]  o;
        logic [31:0] a, d;

        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        vec_t        vecs[$];
        bit          e;
        logic [31:0] rd;
        int          w0, r;
        logic [2:0]  o;
        logic [31:0] a, d;

        for (int i = 0; i < MemWords; i++) ref_mem[i] = 32'h0;
        ref_rdata = 32'h0;
        rst = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        check("reset rdata", rdata, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        vecs.push_back(vec_t'{3'd3, 32'h000, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2});
        vecs.push_back(vec_t'{3'd2, 32'h000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2});
        vecs.push_back(vec_t'{3'd0, 32'h003, 32'h0,        1'b1, 32'hFFFFFFDE, 1'b0, 2});
        vecs.push_back(vec_t'{3'd4, 32'h003, 32'h0,        1'b1, 32'h000000DE, 1'b0, 2});
        vecs.push_back(vec_t'{3'd1, 32'h000, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0, 2});
        vecs.push_back(vec_t'{3'd5, 32'h002, 32'h0,        1'b1, 32'h0000DEAD, 1'b0, 2});
        vecs.push_back(vec_t'{3'd7, 32'h002, 32'h00001234, 1'b0, 32'h0,        1'b0, 3});
        vecs.push_back(vec_t'{3'd2, 32'h000, 32'h0,        1'b1, 32'h1234BEEF, 1'b0, 2});
        vecs.push_back(vec_t'{3'd6, 32'h001, 32'h556677AA, 1'b0, 32'h0,        1'b0, 3});
        vecs.push_back(vec_t'{3'd2, 32'h000, 32'h0,        1'b1, 32'h1234AAEF, 1'b0, 2});
        vecs.push_back(vec_t'{3'd2, 32'h002, 32'h0,        1'b1, 32'h1234AAEF, 1'b1, 2});
        vecs.push_back(vec_t'{3'd7, 32'h005, 32'h0000FFFF, 1'b1, 32'h1234AAEF, 1'b1, 2});
        vecs.push_back(vec_t'{3'd2, 32'h400, 32'h0,        1'b1, 32'h1234AAEF, 1'b1, 2});
        vecs.push_back(vec_t'{3'd3, 32'h404, 32'h99999999, 1'b1, 32'h1234AAEF, 1'b1, 2});
        vecs.push_back(vec_t'{3'd2, 32'h000, 32'h0,        1'b1, 32'h1234AAEF, 1'b0, 2});
        vecs.push_back(vec_t'{3'd3, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 2});
        vecs.push_back(vec_t'{3'd5, 32'h3FE, 32'h0,        1'b1, 32'h0000CAFE, 1'b0, 2});
        vecs.push_back(vec_t'{3'd6, 32'h3FF, 32'h00000080, 1'b0, 32'h0,        1'b0, 3});
        vecs.push_back(vec_t'{3'd0, 32'h3FF, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 2});
        vecs.push_back(vec_t'{3'd1, 32'h3FC, 32'h0,        1'b1, 32'hFFFFF00D, 1'b0, 2});
        vecs.push_back(vec_t'{3'd4, 32'h3FD, 32'h0,        1'b1, 32'h000000F0, 1'b0, 2});

        foreach (vecs[i]) begin
            exercise($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                     vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
            model_step(vecs[i].op, vecs[i].addr, vecs[i].wdata, e, rd);
        end
        check_memory("after table");

        // req held through busy and RESP: exactly one SW, the later request is dropped.
        w0 = we_count;
        req = 1'b1; op = 3'd3; addr = 32'h8; wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        check("hold busy", busy, 1'b1);
        addr = 32'hC; wdata = 32'h22222222;
        @(negedge clk);
        check("hold done", done, 1'b1);
        @(negedge clk);
        req = 1'b0;
        check("hold idle after resp", req_ready, 1'b1);
        check("hold write count", we_count - w0, 1);
        model_step(3'd3, 32'h8, 32'h11111111, e, rd);
        model_step(3'd2, 32'hC, 32'h0, e, rd);
        exercise("hold LW 0xC", 3'd2, 32'hC, 32'h0, 1'b1, rd, 1'b0, 2);
        model_step(3'd2, 32'h8, 32'h0, e, rd);
        exercise("hold LW 0x8", 3'd2, 32'h8, 32'h0, 1'b1, rd, 1'b0, 2);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            o = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r < 7) a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            else if (r < 9) a = ($urandom_range(250, 255) * 4) + $urandom_range(0, 3);
            else a = $urandom | 32'h400;
            d = $urandom;
            model_step(o, a, d, e, rd);
            exercise($sformatf("rand%0d op%0d a%h", n, o, a), o, a, d,
                     m_is_load(o) || e, rd, e, m_lat(o));
        end
        check_memory("after random");
        check("no mem_we outside store states", we_bad, 0);

        // Reset during RMW_WR aborts the write.
        exercise("pre-abort SW 0x4", 3'd3, 32'h4, 32'h55555555, 1'b0, 32'h0, 1'b0, 2);
        model_step(3'd3, 32'h4, 32'h55555555, e, rd);
        req = 1'b1; op = 3'd6; addr = 32'h4; wdata = 32'h000000AA;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("abort busy in rmw_rd", busy, 1'b1);
        @(negedge clk);
        check("abort mem_we in rmw_wr", mem_we, 1'b1);
        w0 = we_count;
        #2 rst = 1'b0;
        #1;
        check("abort mem_we drops", mem_we, 1'b0);
        check("abort req_ready", req_ready, 1'b1);
        check("abort done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < MemWords; i++) ref_mem[i] = 32'h0;
        ref_rdata = 32'h0;
        check("abort write count", we_count - w0, 0);
        check("abort rdata cleared", rdata, 32'h0);
        @(negedge clk);
        exercise("abort LW 0x4", 3'd2, 32'h4, 32'h0, 1'b1, 32'h0, 1'b0, 2);
        check_memory("after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
